// File: rtl/snd_stretched_pulse.sv
// rtl/snd_stretched_pulse.sv - write-domain event strobe to fixed-length level pulse with guaranteed low gap
//
// Ports:
//   wr_clk           write-domain clock, all logic on rising edge
//   wr_resetn        asynchronous active-low reset
//   wr_pulse         event strobe, one wr_clk cycle per event
//   stretched_pulse  registered stretched level sent to the read domain
//   busy             high while a pulse or its trailing gap is in progress
//   pend             one queued event waiting for the current gap to end
//   drop_cnt         saturating count of events lost while one was already queued
module snd_stretched_pulse #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int CW       = 8
) (
    input  logic          wr_clk,
    input  logic          wr_resetn,
    input  logic          wr_pulse,
    output logic          stretched_pulse,
    output logic          busy,
    output logic          pend,
    output logic [CW-1:0] drop_cnt
);

    localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int PW      = $clog2(MAX_CYC + 1);
    localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYC - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          pend_nxt;
    logic          drop_inc;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        pend_nxt  = pend;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pulse) begin
                    state_nxt = HIGH;
                    phase_nxt = '0;
                end
            end
            HIGH: begin
                if (phase == HIGH_LAST) begin
                    state_nxt = GAP;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
                if (wr_pulse) begin
                    if (pend) drop_inc = 1'b1;
                    else      pend_nxt = 1'b1;
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    phase_nxt = '0;
                    if (pend) begin
                        // Queued event launches; a strobe arriving now takes its slot.
                        state_nxt = HIGH;
                        pend_nxt  = wr_pulse;
                    end else if (wr_pulse) begin
                        state_nxt = HIGH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                    if (wr_pulse) begin
                        if (pend) drop_inc = 1'b1;
                        else      pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_resetn) begin
        if (!wr_resetn) begin
            state           <= IDLE;
            phase           <= '0;
            pend            <= 1'b0;
            stretched_pulse <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            pend            <= pend_nxt;
            // Registered from next state so the output is a clean flop with one cycle latency.
            stretched_pulse <= (state_nxt == HIGH);
            if (drop_inc && (drop_cnt != {CW{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_snd_stretched_pulse.sv
// tb/tb_snd_stretched_pulse.sv - scoreboard testbench for snd_stretched_pulse
module tb_snd_stretched_pulse;

    localparam int H = 4;
    localparam int G = 4;

    logic       wr_clk;
    logic       wr_resetn;
    logic       wr_pulse;
    logic       stretched_pulse;
    logic       busy;
    logic       pend;
    logic [7:0] drop_cnt;

    logic       p2;
    logic       sp2;
    logic       busy2;
    logic       pend2;
    logic [1:0] drop2;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int base    = 0;
    int exp_q[$];
    logic prev_sp = 1'b0;
    int   start_c = 0;

    snd_stretched_pulse #(.HIGH_CYC(H), .GAP_CYC(G), .CW(8)) u_dut (
        .wr_clk          (wr_clk),
        .wr_resetn       (wr_resetn),
        .wr_pulse        (wr_pulse),
        .stretched_pulse (stretched_pulse),
        .busy            (busy),
        .pend            (pend),
        .drop_cnt        (drop_cnt)
    );

    snd_stretched_pulse #(.HIGH_CYC(H), .GAP_CYC(G), .CW(2)) u_dut2 (
        .wr_clk          (wr_clk),
        .wr_resetn       (wr_resetn),
        .wr_pulse        (p2),
        .stretched_pulse (sp2),
        .busy            (busy2),
        .pend            (pend2),
        .drop_cnt        (drop2)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int actual, input int expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc - base);
        end
    endtask

    // Scoreboard side: each rising edge of stretched_pulse pops the next expected start cycle.
    always @(negedge wr_clk) begin
        if (!wr_resetn) begin
            prev_sp <= 1'b0;
        end else begin
            if (stretched_pulse && !prev_sp) begin
                if (exp_q.size() == 0) begin
                    check_val("rise_unexpected", cyc - base, -1);
                end else begin
                    check_val("rise_cycle", cyc - base, exp_q.pop_front());
                end
                start_c <= cyc - base;
            end
            if (!stretched_pulse && prev_sp) begin
                check_val("high_width", cyc - base - start_c, H);
            end
            prev_sp <= stretched_pulse;
        end
    end

    task automatic goto(input int n);
        while (cyc - base < n) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic strobe_at(input int n, input bit sel2);
        goto(n);
        if (sel2) p2 = 1'b1;
        else      wr_pulse = 1'b1;
        goto(n + 1);
        p2       = 1'b0;
        wr_pulse = 1'b0;
    endtask

    task automatic do_reset();
        wr_pulse  = 1'b0;
        p2        = 1'b0;
        wr_resetn = 1'b0;
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        wr_resetn = 1'b1;
        @(posedge wr_clk);
        #1;
        exp_q.delete();
        base = cyc;
    endtask

    task automatic end_test(input string tag);
        goto(40);
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_resetn = 1'b0;
        wr_pulse  = 1'b0;
        p2        = 1'b0;
        #2;
        check_val("rst_sp", stretched_pulse, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pend", pend, 0);
        check_val("rst_drop", drop_cnt, 0);

        // 1: single event
        do_reset();
        exp_q.push_back(11); strobe_at(10, 0);
        goto(11); check_val("t1_busy11", busy, 1);
        goto(15); check_val("t1_sp15", stretched_pulse, 0);
        goto(18); check_val("t1_busy18", busy, 1);
        goto(19); check_val("t1_busy19", busy, 0);
        check_val("t1_pend", pend, 0);
        check_val("t1_drop", drop_cnt, 0);
        end_test("t1_missing");

        // 2: queued event
        do_reset();
        exp_q.push_back(11); strobe_at(10, 0);
        exp_q.push_back(19); strobe_at(12, 0);
        goto(13); check_val("t2_pend13", pend, 1);
        goto(19); check_val("t2_pend19", pend, 0);
        check_val("t2_drop", drop_cnt, 0);
        end_test("t2_missing");

        // 3: drops
        do_reset();
        exp_q.push_back(11); strobe_at(10, 0);
        exp_q.push_back(19); strobe_at(12, 0);
        strobe_at(13, 0);
        strobe_at(14, 0);
        goto(15); check_val("t3_pend", pend, 1);
        check_val("t3_drop", drop_cnt, 2);
        end_test("t3_missing");
        check_val("t3_drop_end", drop_cnt, 2);

        // 4a: strobe on last gap cycle launches with no idle cycle
        do_reset();
        exp_q.push_back(11); strobe_at(10, 0);
        goto(18); check_val("t4a_sp18", stretched_pulse, 0);
        exp_q.push_back(19); strobe_at(18, 0);
        check_val("t4a_sp19", stretched_pulse, 1);
        check_val("t4a_busy19", busy, 1);
        check_val("t4a_pend19", pend, 0);
        end_test("t4a_missing");

        // 4b: pending launch and new strobe coincide
        do_reset();
        exp_q.push_back(11); strobe_at(10, 0);
        exp_q.push_back(19); strobe_at(12, 0);
        exp_q.push_back(27); strobe_at(18, 0);
        check_val("t4b_pend19", pend, 1);
        goto(27); check_val("t4b_pend27", pend, 0);
        check_val("t4b_drop", drop_cnt, 0);
        end_test("t4b_missing");

        // 5: saturation on a CW=2 instance
        do_reset();
        strobe_at(10, 1);
        strobe_at(12, 1);
        check_val("t5_pend", pend2, 1);
        check_val("t5_drop0", drop2, 0);
        strobe_at(13, 1);
        strobe_at(14, 1);
        strobe_at(15, 1);
        check_val("t5_drop3", drop2, 3);
        strobe_at(16, 1);
        strobe_at(17, 1);
        check_val("t5_drop_sat", drop2, 3);
        end_test("t5_missing");

        // 6: async reset mid-pulse
        do_reset();
        exp_q.push_back(9); strobe_at(8, 0);
        strobe_at(9, 0);
        strobe_at(10, 0);
        goto(11);
        check_val("t6_sp_pre", stretched_pulse, 1);
        check_val("t6_pend_pre", pend, 1);
        check_val("t6_drop_pre", drop_cnt, 1);
        goto(12);
        #2;
        wr_resetn = 1'b0;
        #1;
        check_val("t6_sp_rst", stretched_pulse, 0);
        check_val("t6_busy_rst", busy, 0);
        check_val("t6_pend_rst", pend, 0);
        check_val("t6_drop_rst", drop_cnt, 0);
        goto(14);
        wr_resetn = 1'b1;
        exp_q.push_back(21); strobe_at(20, 0);
        goto(25); check_val("t6_sp25", stretched_pulse, 0);
        end_test("t6_missing");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
